avmm_req_master: RTL and testbench
==================================

# avmm_req_master

Single-outstanding AVMM master that sits directly upstream of the page-protected AVMM memory: it accepts read/write requests on a valid/ready request channel, drives the memory's `address`/`write`/`read`/`writedata` pins one transaction at a time, and returns read data on a valid/ready response channel. The memory's second page (addresses 128–255) is write-protected. Optionally, the master inserts the two-word page-2 unlock sequence automatically before the first page-2 write.

## Interface
Parameters:
- `AW`, 8: address width; must match the memory.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  master can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  target address.
- `req_wdata`  in  DW  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DW  captured read data.
- `avm_address`  out  AW  to memory `address`.
- `avm_write`  out  1  to memory `write`.
- `avm_read`  out  1  to memory `read`.
- `avm_writedata`  out  DW  to memory `writedata`.
- `avm_readdata`  in  DW  from memory `readdata`; valid one cycle after `avm_read`.
- `unlocked`  out  1  master believes page 2 is currently unlocked.

## Operation
- **Request handshake.**
  - A request is accepted when `req_valid && req_ready`.
  - `req_ready = (state == IDLE)`.
  - Address, data and type are latched at acceptance.
- **FSM states.** IDLE, UNLK_HI, UNLK_LO, WR, RD, RDCAP, RSP.
- **Transitions from IDLE on acceptance:**
  - Read → RD.
  - Write with addr ≥ 128, `unlocked == 0` and the feature enabled → UNLK_HI.
  - Any other write → WR.
- **Unlock and write states:**
  - UNLK_HI drives a write of 23 to address 127, then goes to UNLK_LO.
  - UNLK_LO drives a write of 79 to address 126, sets `unlocked`, then goes to WR.
  - WR drives `avm_write = 1` with the latched address and data, then goes to IDLE.
  - Writes are posted: no response is generated.
- **Read states:**
  - RD drives `avm_read = 1`, then goes to RDCAP.
  - RDCAP samples `avm_readdata` into `rsp_rdata`, then goes to RSP.
  - RSP holds `rsp_valid = 1` until `rsp_ready`, then goes to IDLE. `rsp_rdata` is stable while `rsp_valid` is high.
- **Unlock tracking.**
  - Any user write to address 126 or 127 clears `unlocked`, because the key may have been overwritten.
  - User reads never change `unlocked`.
- **Pin defaults.**
  - `avm_write` and `avm_read` are never high together.
  - Both are 0 outside WR/UNLK_*/RD.
  - `avm_address`/`avm_writedata` are 0 in IDLE.
- **Out-of-range addresses.** None possible: AW = 8 spans the full 0–255 range.

## Timing
- **Reset values.** `rst = 1` at any edge forces:
  - state IDLE;
  - `req_ready` = 1 in the cycle after reset;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `unlocked` = 0;
  - all `avm_*` outputs = 0.
  - Any in-flight transaction, including a partially sent unlock sequence, is dropped.
- **Write, no unlock.**
  - Handshake in cycle 0; `avm_write` high in cycle 1.
  - `req_ready` high again in cycle 2 (throughput 1 write per 2 cycles).
- **Write with unlock.**
  - `avm_write` high in cycles 1, 2, 3 (key hi, key lo, target).
  - `req_ready` high in cycle 4.
- **Read.**
  - `avm_read` in cycle 1; capture in cycle 2.
  - `rsp_valid` high from cycle 3.
  - If `rsp_ready` is already high in cycle 3, `req_ready` is high in cycle 4.
- **Response backpressure.** No new request is accepted while a response is pending.
- **Reset vs. handshake.** `rst` takes priority over any simultaneous request or response handshake.

## Configuration
- **`AVMM_AUTO_UNLOCK_EN` defined:**
  - Automatic unlock insertion as described above.
  - `unlocked` is tracked.
- **Not defined:**
  - Page-2 writes go straight to WR. If the memory is locked, the memory silently drops them.
  - UNLK_HI/UNLK_LO are unreachable and may be omitted.
  - `unlocked` is tied to 0.

## Structure
- **Package `avmm_pkg`:**
  - state enum `avmm_mst_state_t`;
  - `PAGE2_BASE = 128`;
  - `KEY_HI_ADDR = 127`, `KEY_LO_ADDR = 126`;
  - `KEY_HI = 23`, `KEY_LO = 79`.
- The memory model imports the same key constants.
- Single module; no sub-module is warranted. The FSM and response register are inline.

## Test plan
- Reset, then write addr 5 data 0xAA, then read addr 5 → `avm_write` in cycle 1, `rsp_rdata = 0xAA` with `rsp_valid` in cycle 3 of the read.
- Feature enabled, write addr 200 data 0x5C → writes to 127=23, 126=79 and 200=0x5C in consecutive cycles; `unlocked = 1`; read 200 returns 0x5C.
- Feature enabled, after unlock: user write 127=0, then write 201=0x11 → unlock sequence is reinserted; read 201 returns 0x11.
- Feature disabled, write 200=0x33 after reset, then read 200 → single `avm_write`; returned data is 0 (locked memory dropped the write).
- Read addr 5 with `rsp_ready = 0` for 4 cycles → `rsp_valid` and `rsp_rdata` held stable, `req_ready = 0` throughout; both release the cycle after `rsp_ready`.
- Assert `rst` in cycle 2 of an unlock-write → all `avm_*` = 0 and `unlocked = 0` in the next cycle; the target write is never issued.

Source files
------------

// File: rtl/avmm_pkg.sv
// Shared types and key constants for the AVMM request master and the page-protected memory.
package avmm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNLK_HI,
    UNLK_LO,
    WR,
    RD,
    RDCAP,
    RSP
  } avmm_mst_state_t;

  localparam logic [7:0] PAGE2_BASE  = 8'd128;
  localparam logic [7:0] KEY_HI_ADDR = 8'd127;
  localparam logic [7:0] KEY_LO_ADDR = 8'd126;
  localparam logic [7:0] KEY_HI      = 8'd23;
  localparam logic [7:0] KEY_LO      = 8'd79;

endpackage

// File: rtl/avmm_req_master.sv
// Single-outstanding AVMM master with a valid/ready request and response channel.
// Define AVMM_AUTO_UNLOCK_EN to insert the page-2 unlock key writes before the first page-2 write.
module avmm_req_master
  import avmm_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] avm_address,
  output logic          avm_write,
  output logic          avm_read,
  output logic [DW-1:0] avm_writedata,
  input  logic [DW-1:0] avm_readdata,
  output logic          unlocked
);

  localparam logic [AW-1:0] KEY_HI_A = AW'(KEY_HI_ADDR);
  localparam logic [AW-1:0] KEY_LO_A = AW'(KEY_LO_ADDR);
  localparam logic [DW-1:0] KEY_HI_D = DW'(KEY_HI);
  localparam logic [DW-1:0] KEY_LO_D = DW'(KEY_LO);

  avmm_mst_state_t state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]   avm_address_q, avm_address_d;
  logic [DW-1:0]   avm_writedata_q, avm_writedata_d;
  logic            avm_write_q, avm_write_d;
  logic            avm_read_q, avm_read_d;
`ifdef AVMM_AUTO_UNLOCK_EN
  logic            unlocked_q, unlocked_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef AVMM_AUTO_UNLOCK_EN
    unlocked_d  = unlocked_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!req_write) begin
            state_d = RD;
          end else begin
            state_d = WR;
`ifdef AVMM_AUTO_UNLOCK_EN
            // A user write to either key word may have destroyed the key.
            if (req_addr == KEY_HI_A || req_addr == KEY_LO_A)
              unlocked_d = 1'b0;
            if (req_addr >= AW'(PAGE2_BASE) && !unlocked_q)
              state_d = UNLK_HI;
`endif
          end
        end
      end
      UNLK_HI: state_d = UNLK_LO;
      UNLK_LO: begin
        state_d = WR;
`ifdef AVMM_AUTO_UNLOCK_EN
        unlocked_d = 1'b1;
`endif
      end
      WR:    state_d = IDLE;
      RD:    state_d = RDCAP;
      RDCAP: begin
        rsp_rdata_d = avm_readdata;
        state_d     = RSP;
      end
      RSP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the next state so they appear registered in that state.
    avm_write_d     = (state_d == UNLK_HI) || (state_d == UNLK_LO) || (state_d == WR);
    avm_read_d      = (state_d == RD);
    rsp_valid_d     = (state_d == RSP);
    avm_address_d   = '0;
    avm_writedata_d = '0;
    case (state_d)
      UNLK_HI: begin
        avm_address_d   = KEY_HI_A;
        avm_writedata_d = KEY_HI_D;
      end
      UNLK_LO: begin
        avm_address_d   = KEY_LO_A;
        avm_writedata_d = KEY_LO_D;
      end
      WR: begin
        avm_address_d   = addr_d;
        avm_writedata_d = wdata_d;
      end
      RD:      avm_address_d = addr_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      rsp_rdata_q     <= '0;
      rsp_valid_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      avm_write_q     <= 1'b0;
      avm_read_q      <= 1'b0;
`ifdef AVMM_AUTO_UNLOCK_EN
      unlocked_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_valid_q     <= rsp_valid_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      avm_write_q     <= avm_write_d;
      avm_read_q      <= avm_read_d;
`ifdef AVMM_AUTO_UNLOCK_EN
      unlocked_q      <= unlocked_d;
`endif
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign avm_write     = avm_write_q;
  assign avm_read      = avm_read_q;
`ifdef AVMM_AUTO_UNLOCK_EN
  assign unlocked      = unlocked_q;
`else
  assign unlocked      = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_req_master.sv
// Directed bench for avmm_req_master with a behavioural page-protected memory.
// Expectations follow AVMM_AUTO_UNLOCK_EN when the bench is built with it.
module tb_avmm_req_master;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_writes;
    logic        exp_unl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [7:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        unlocked;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256] = '{default: '0};
  logic        mem_hi_seen = 1'b0;
  logic        mem_unl     = 1'b0;
  logic [31:0] mem_rdata   = '0;
  int          tgt_hits    = 0;

  logic [7:0]  wlog_addr [8];
  logic [31:0] wlog_data [8];
  vec_t        vecs [8];
  int          nvec;

  avmm_req_master #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .unlocked(unlocked)
  );

  always #5 clk = ~clk;

  assign avm_readdata = mem_rdata;

  // Memory: page 2 accepts writes only after 23 to 127 then 79 to 126; other key writes relock.
  always @(posedge clk) begin
    if (avm_write) begin
      if (avm_address < 8'd128 || mem_unl)
        mem[avm_address] <= avm_writedata;
      if (avm_address == 8'd127 && avm_writedata == 32'd23) begin
        mem_hi_seen <= 1'b1;
        mem_unl     <= 1'b0;
      end else if (avm_address == 8'd126 && avm_writedata == 32'd79 && mem_hi_seen) begin
        mem_unl     <= 1'b1;
        mem_hi_seen <= 1'b0;
      end else if (avm_address == 8'd126 || avm_address == 8'd127) begin
        mem_unl     <= 1'b0;
        mem_hi_seen <= 1'b0;
      end else begin
        mem_hi_seen <= 1'b0;
      end
      if (avm_address == 8'd210)
        tgt_hits <= tgt_hits + 1;
    end
    if (avm_read)
      mem_rdata <= mem[avm_address];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    int nwr;
    @(negedge clk);
    checkOutput("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.wr) begin
      checkOutput("wr_cycle1", {31'b0, avm_write}, 32'd1);
      cyc = 1;
      nwr = 0;
      while (!req_ready && cyc < 10) begin
        if (avm_write && nwr < 8) begin
          wlog_addr[nwr] = avm_address;
          wlog_data[nwr] = avm_writedata;
          nwr++;
        end
        if (avm_read)
          checkOutput("rd_during_wr", {31'b0, avm_read}, 32'd0);
        @(negedge clk);
        cyc++;
      end
      checkOutput("wr_latency", cyc, v.exp_writes + 1);
      checkOutput("wr_count", nwr, v.exp_writes);
      if (v.exp_writes == 3 && nwr == 3) begin
        checkOutput("key_hi_addr", {24'b0, wlog_addr[0]}, 32'd127);
        checkOutput("key_hi_data", wlog_data[0], 32'd23);
        checkOutput("key_lo_addr", {24'b0, wlog_addr[1]}, 32'd126);
        checkOutput("key_lo_data", wlog_data[1], 32'd79);
      end
      if (nwr > 0) begin
        checkOutput("tgt_addr", {24'b0, wlog_addr[nwr-1]}, {24'b0, v.addr});
        checkOutput("tgt_data", wlog_data[nwr-1], v.wdata);
      end
      checkOutput("wr_idle_pins", {avm_write, avm_read, avm_address, 22'b0}, 32'd0);
    end else begin
      checkOutput("rd_cycle1", {31'b0, avm_read}, 32'd1);
      checkOutput("rd_cycle1_wr", {31'b0, avm_write}, 32'd0);
      checkOutput("rd_addr", {24'b0, avm_address}, {24'b0, v.addr});
      @(negedge clk);
      checkOutput("rd_cycle2_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rd_cycle2_read", {31'b0, avm_read}, 32'd0);
      @(negedge clk);
      checkOutput("rd_cycle3_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("rd_data", rsp_rdata, v.exp_rdata);
      @(negedge clk);
      checkOutput("rd_cycle4_ready", {31'b0, req_ready}, 32'd1);
      checkOutput("rd_cycle4_valid", {31'b0, rsp_valid}, 32'd0);
    end
    checkOutput("unlocked", {31'b0, unlocked}, {31'b0, v.exp_unl});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t extra;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;

    vecs[0] = '{1'b1, 8'd5, 32'hAA, 32'h0, 1, 1'b0};
    vecs[1] = '{1'b0, 8'd5, 32'h0, 32'hAA, 0, 1'b0};
`ifdef AVMM_AUTO_UNLOCK_EN
    vecs[2] = '{1'b1, 8'd200, 32'h5C, 32'h0, 3, 1'b1};
    vecs[3] = '{1'b0, 8'd200, 32'h0, 32'h5C, 0, 1'b1};
    vecs[4] = '{1'b1, 8'd127, 32'h0, 32'h0, 1, 1'b0};
    vecs[5] = '{1'b1, 8'd201, 32'h11, 32'h0, 3, 1'b1};
    vecs[6] = '{1'b0, 8'd201, 32'h0, 32'h11, 0, 1'b1};
    nvec = 7;
`else
    vecs[2] = '{1'b1, 8'd200, 32'h33, 32'h0, 1, 1'b0};
    vecs[3] = '{1'b0, 8'd200, 32'h0, 32'h0, 0, 1'b0};
    nvec = 4;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp", {rsp_valid, unlocked, 30'b0}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_avm_ctl", {avm_write, avm_read, avm_address, 22'b0}, 32'd0);
    checkOutput("rst_avm_wdata", avm_writedata, 32'd0);

    for (int i = 0; i < nvec; i++)
      applyStimulus(vecs[i]);

    // Response backpressure: hold the response for four cycles.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rdata", rsp_rdata, 32'hAA);
      checkOutput("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'b0, req_ready}, 32'd1);

`ifdef AVMM_AUTO_UNLOCK_EN
    // Relock, then reset in the middle of the inserted key sequence.
    extra = '{1'b1, 8'd126, 32'h5, 32'h0, 1, 1'b0};
    applyStimulus(extra);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd210; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstmid_key_hi", {24'b0, avm_address}, 32'd127);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid_avm_ctl", {avm_write, avm_read, avm_address, 22'b0}, 32'd0);
    checkOutput("rstmid_avm_wdata", avm_writedata, 32'd0);
    checkOutput("rstmid_unlocked", {31'b0, unlocked}, 32'd0);
    checkOutput("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("rstmid_no_target", tgt_hits, 32'd0);
`else
    extra = '{1'b1, 8'd210, 32'h77, 32'h0, 1, 1'b0};
    applyStimulus(extra);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
